sys_arr_ctrl: RTL and testbench

Sequencer for one square systolic array built from chained PE rows. It runs one matrix-multiply tile. First it fetches ARR_SIZE weight words from weight memory and asserts wwrite so the weights shift into the PE rows. Next it streams NUM_VEC data vectors by driving the array's active input. Finally it marks which cycles carry valid accumulated sums at the bottom of the array and handshakes start/busy/done with the top-level tile scheduler.

---
 rtl/sys_arr_pkg.sv | 18 +
 rtl/sys_arr_delay.sv | 33 +++
 rtl/sys_arr_ctrl.sv | 102 ++++++++++
 tb/tb_sys_arr_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and sizing helpers for the systolic-array tile sequencer.
// Holds the state encoding, the default array size and the derived widths/latency.
package sys_arr_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  localparam int DEF_ARR_SIZE = 16;

  // Active-to-bottom-row latency of an N x N array.
  function automatic int lat_f(input int n);
    return 2 * n;
  endfunction

  function automatic int addr_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_arr_delay.sv
// Single-bit shift-register delay line of DEPTH stages.
// Async reset plus a synchronous flush that empties every stage at once.
module sys_arr_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_p0;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      sr_p0 <= '0;
        else if (flush) sr_p0 <= '0;
        else            sr_p0 <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      sr_p0 <= '0;
        else if (flush) sr_p0 <= '0;
        else            sr_p0 <= {sr_p0[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr_p0[DEPTH-1];

endmodule

// File: rtl/sys_arr_ctrl.sv
// Tile sequencer for a square systolic array: weight load, vector stream,
// drain of bottom-row results, and start/busy/done handshake.
module sys_arr_ctrl
  import sys_arr_pkg::*;
#(
  parameter int ARR_SIZE = DEF_ARR_SIZE,
  parameter int VEC_W    = 16,
  parameter int LAT      = lat_f(ARR_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [VEC_W-1:0]              num_vec,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd_en,
  output logic [addr_w_f(ARR_SIZE)-1:0] w_addr,
  output logic [ARR_SIZE-1:0]           wwrite,
  output logic                          d_rd_en,
  output logic [VEC_W-1:0]              d_addr,
  output logic                          active,
  output logic                          out_valid,
  output logic [VEC_W-1:0]              out_addr
);

  localparam int AW = addr_w_f(ARR_SIZE);
  localparam logic [AW-1:0]    W_LAST = AW'(ARR_SIZE - 1);
  localparam logic [AW-1:0]    W_ONE  = AW'(1);
  localparam logic [VEC_W-1:0] V_ONE  = VEC_W'(1);

  state_t           state, nxt;
  logic [AW-1:0]    w_cnt;
  logic [VEC_W-1:0] d_cnt, o_cnt, nv_q;
  logic             accept;
  logic             wwrite_bit, active_bit, ov_bit;

  assign accept = (state == IDLE) && start && !abort && (num_vec != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Abort overrides every transition; in IDLE it also drops a coincident start.
  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) nxt = (num_vec != '0) ? LOAD_W : DONE;
        LOAD_W:  if (w_cnt == W_LAST) nxt = STREAM;
        STREAM:  if (d_cnt == nv_q - V_ONE) nxt = DRAIN;
        DRAIN:   if (ov_bit && (o_cnt == nv_q - V_ONE)) nxt = DONE;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Counters restart whenever their phase is left, so abort leaves them cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nv_q  <= '0;
      w_cnt <= '0;
      d_cnt <= '0;
      o_cnt <= '0;
    end else begin
      if (accept) nv_q <= num_vec;
      w_cnt <= (state == LOAD_W && nxt == LOAD_W) ? w_cnt + W_ONE : '0;
      d_cnt <= (state == STREAM && nxt == STREAM) ? d_cnt + V_ONE : '0;
      if (nxt == IDLE || nxt == DONE) o_cnt <= '0;
      else if (ov_bit)                o_cnt <= o_cnt + V_ONE;
    end
  end

  // Stage boundary: memory read enables -> write strobe / active -> bottom-row valid.
  sys_arr_delay #(.DEPTH(1)) u_wwrite_dly (
    .clk(clk), .reset(reset), .flush(abort), .din(w_rd_en), .dout(wwrite_bit)
  );

  sys_arr_delay #(.DEPTH(1)) u_active_dly (
    .clk(clk), .reset(reset), .flush(abort), .din(d_rd_en), .dout(active_bit)
  );

  sys_arr_delay #(.DEPTH(LAT)) u_valid_dly (
    .clk(clk), .reset(reset), .flush(abort), .din(active_bit), .dout(ov_bit)
  );

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign w_rd_en   = (state == LOAD_W);
  assign w_addr    = w_cnt;
  assign d_rd_en   = (state == STREAM);
  assign d_addr    = d_cnt;
  assign wwrite    = {ARR_SIZE{wwrite_bit}};
  assign active    = active_bit;
  assign out_valid = ov_bit;
  assign out_addr  = o_cnt;

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// Scoreboard bench for sys_arr_ctrl (N=4, LAT=8): per-cycle expected output
// vectors are queued from the tile timing equations when start is driven.
module tb_sys_arr_ctrl;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [VW-1:0] num_vec;
  logic          busy, done, w_rd_en, d_rd_en, active, out_valid;
  logic [1:0]    w_addr;
  logic [N-1:0]  wwrite;
  logic [VW-1:0] d_addr, out_addr;

  sys_arr_ctrl #(.ARR_SIZE(N), .VEC_W(VW), .LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .abort(abort),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .wwrite(wwrite),
    .d_rd_en(d_rd_en), .d_addr(d_addr), .active(active),
    .out_valid(out_valid), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [43:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  function automatic logic [43:0] pk(input logic b, input logic dn, input logic wr,
                                     input logic [1:0] wa, input logic [3:0] ww,
                                     input logic dr, input logic [15:0] da,
                                     input logic ac, input logic ov, input logic [15:0] oa);
    return {b, dn, wr, wa, ww, dr, da, ac, ov, (ov ? oa : 16'h0)};
  endfunction

  function automatic logic [43:0] dut_vec();
    return pk(busy, done, w_rd_en, w_addr, wwrite, d_rd_en, d_addr, active, out_valid, out_addr);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Expected vectors for a tile whose start is sampled at the end of cycle s.
  task automatic push_tile(input int s, input int nv);
    exp_t e;
    int   total;
    if (nv == 0) begin
      e.cyc = s + 1;
      e.v   = pk(1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);
      q.push_back(e);
      return;
    end
    total = N + 2 + nv + L;
    for (int k = 1; k <= total; k++) begin
      logic wr, dr, ac, ov;
      wr    = (k >= 1) && (k <= N);
      dr    = (k >= N + 1) && (k <= N + nv);
      ac    = (k >= N + 2) && (k <= N + 1 + nv);
      ov    = (k >= N + 2 + L) && (k <= N + 1 + nv + L);
      e.cyc = s + k;
      e.v   = pk(1'b1, (k == total), wr, (wr ? 2'(k - 1) : 2'd0),
                 ((k >= 2 && k <= N + 1) ? 4'hF : 4'h0),
                 dr, (dr ? 16'(k - N - 1) : 16'd0), ac,
                 ov, (ov ? 16'(k - N - 2 - L) : 16'd0));
      q.push_back(e);
    end
  endtask

  task automatic trunc_after(input int c);
    while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [43:0] exp_v;
      exp_v = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_v = q[0].v;
        void'(q.pop_front());
      end
      chk($sformatf("cyc%0d", cyc), 64'(dut_vec()), 64'(exp_v));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic run_start(input int nv);
    start   = 1'b1;
    num_vec = VW'(nv);
    push_tile(cyc, nv);
    tick();
    start   = 1'b0;
    num_vec = '0;
  endtask

  int s, s2;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    num_vec = '0;
    repeat (3) tick();
    chk("reset_state", 64'(dut_vec()), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Basic tile, num_vec=3
    s = cyc;
    run_start(3);
    wait_until(s + 20);

    // Empty tile
    s = cyc;
    run_start(0);
    wait_until(s + 4);

    // Start pulses while busy are ignored
    s = cyc;
    run_start(3);
    wait_until(s + 3);
    start = 1'b1; num_vec = 16'd7; tick(); start = 1'b0; num_vec = '0;
    wait_until(s + 10);
    start = 1'b1; num_vec = 16'd7; tick(); start = 1'b0; num_vec = '0;
    wait_until(s + 18);
    s2 = cyc;
    run_start(2);
    wait_until(s2 + N + 2 + 2 + L + 3);

    // Abort in cycle 7, then a fresh tile from cycle 10
    s = cyc;
    run_start(3);
    wait_until(s + 7);
    abort = 1'b1;
    trunc_after(s + 7);
    tick();
    abort = 1'b0;
    wait_until(s + 10);
    run_start(3);
    wait_until(s + 10 + 20);

    // Abort and start together in IDLE: start dropped
    start = 1'b1; abort = 1'b1; num_vec = 16'd3;
    tick();
    start = 1'b0; abort = 1'b0; num_vec = '0;
    repeat (3) tick();

    // Asynchronous reset mid-DRAIN
    s = cyc;
    run_start(3);
    wait_until(s + 12);
    #2;
    trunc_after(s + 11);
    reset = 1'b1;
    #1;
    chk("async_reset", 64'(dut_vec()), 64'd0);
    repeat (2) tick();
    #1;
    reset = 1'b0;
    tick();
    s = cyc;
    run_start(2);
    wait_until(s + N + 2 + 2 + L + 3);

    // Start held high continuously, num_vec=1
    s = cyc;
    start   = 1'b1;
    num_vec = 16'd1;
    push_tile(s, 1);
    push_tile(s + 16, 1);
    push_tile(s + 32, 1);
    wait_until(s + 33);
    start   = 1'b0;
    num_vec = '0;
    wait_until(s + 32 + 20);

    chk("queue_drained", 64'(q.size()), 64'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
